// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch stage. Issues sequential word-aligned reads
//                to instruction memory, buffers in-order responses as
//                {pc, insn} pairs in a small FIFO and hands them to decode.
//                Redirects flush the FIFO and discard responses in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid_o,
    output logic [AWIDTH-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic [DWIDTH-1:0] resp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] pc_o
);

    // DEPTH is restricted to 2 or 4, so pointers are 1 or 2 bits and wrap
    // naturally modulo DEPTH.
    localparam int c_PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OCC_W = c_CNT_W + 1;

    // Per-entry state encoding
    localparam logic [1:0] c_FREE     = 2'd0;
    localparam logic [1:0] c_RESERVED = 2'd1;
    localparam logic [1:0] c_FILLED   = 2'd2;

    localparam logic [AWIDTH-1:0] c_ALIGN_MASK = ~AWIDTH'(3);

    logic [1:0]         r_state [DEPTH];
    logic [AWIDTH-1:0]  r_pc    [DEPTH];
    logic [DWIDTH-1:0]  r_insn  [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_PTR_W-1:0] r_fill_ptr;     // oldest RESERVED entry
    logic [c_CNT_W-1:0] r_drop_cnt;     // responses still owed to a flushed stream
    logic [AWIDTH-1:0]  r_fetch_pc;

    logic [c_CNT_W-1:0] w_n_reserved;
    logic [c_CNT_W-1:0] w_n_filled;
    logic [c_OCC_W-1:0] w_occupancy;
    logic               w_issue;
    logic               w_head_filled;
    logic               w_dequeue;
    logic               w_resp_drop;
    logic               w_resp_fill;
    logic               w_resp_taken;

    // Count entries waiting for data and entries holding data
    always_comb begin
        w_n_reserved = '0;
        w_n_filled   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_state[i] == c_RESERVED) begin
                w_n_reserved = w_n_reserved + c_CNT_W'(1);
            end
            if (r_state[i] == c_FILLED) begin
                w_n_filled = w_n_filled + c_CNT_W'(1);
            end
        end
    end

    // Pending drops still occupy capacity: their responses have not arrived
    // yet, so issuing more would exceed the outstanding-request limit.
    assign w_occupancy = c_OCC_W'(w_n_reserved) + c_OCC_W'(w_n_filled)
                       + c_OCC_W'(r_drop_cnt);

    // Capacity is judged on registered state only; a dequeue this cycle does
    // not open a slot until the next cycle.
    assign req_valid_o = rst & ~redirect_i & (w_occupancy < c_OCC_W'(DEPTH));
    assign req_addr_o  = r_fetch_pc;
    assign w_issue     = req_valid_o & req_ready_i;

    // A response either pays off a pending drop or fills the oldest
    // reservation; with neither pending it is ignored.
    assign w_resp_drop  = resp_valid_i & (r_drop_cnt != '0);
    assign w_resp_fill  = resp_valid_i & (r_drop_cnt == '0) & (w_n_reserved != '0);
    assign w_resp_taken = w_resp_drop | w_resp_fill;

    assign w_head_filled = (r_state[r_head] == c_FILLED);
    assign w_dequeue     = w_head_filled & ready_i;

    assign valid_o = w_head_filled;
    assign insn_o  = w_head_filled ? r_insn[r_head] : '0;
    assign pc_o    = w_head_filled ? r_pc[r_head]   : '0;

    // Control state: pointers, entry states, drop counter and fetch PC
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_pc <= BASEADDR & c_ALIGN_MASK;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_FREE;
            end
        end else if (redirect_i) begin
            // Every in-flight reservation becomes a drop; a response arriving
            // right now is already one of those and is discarded here.
            r_fetch_pc <= redirect_pc_i & c_ALIGN_MASK;
            r_head     <= '0;
            r_tail     <= '0;
            r_fill_ptr <= '0;
            r_drop_cnt <= r_drop_cnt + w_n_reserved
                        - (w_resp_taken ? c_CNT_W'(1) : c_CNT_W'(0));
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= c_FREE;
            end
        end else begin
            if (w_issue) begin
                r_state[r_tail] <= c_RESERVED;
                r_tail          <= r_tail + c_PTR_W'(1);
                r_fetch_pc      <= r_fetch_pc + AWIDTH'(4);
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
            if (w_resp_fill) begin
                r_state[r_fill_ptr] <= c_FILLED;
                r_fill_ptr          <= r_fill_ptr + c_PTR_W'(1);
            end
            if (w_dequeue) begin
                r_state[r_head] <= c_FREE;
                r_head          <= r_head + c_PTR_W'(1);
            end
        end
    end

    // Payload storage; validity is carried entirely by r_state
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pc[r_tail] <= r_fetch_pc;
        end
        if (w_resp_fill && rst && !redirect_i) begin
            r_insn[r_fill_ptr] <= resp_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Randomised scoreboard bench for fetch_queue with an in-order
//                memory model and a queue-based reference of the fetch stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk;
    logic        rst;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_valid_i;
    logic [31:0] resp_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] insn_o;
    logic [31:0] pc_o;

    fetch_queue #(
        .AWIDTH  (32),
        .DWIDTH  (32),
        .BASEADDR(BASE),
        .DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .req_ready_i  (req_ready_i),
        .resp_valid_i (resp_valid_i),
        .resp_data_i  (resp_data_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .insn_o       (insn_o),
        .pc_o         (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        bit          filled;
    } exp_t;

    mem_t        mem_q[$];     // requests the memory still owes a response for
    exp_t        exp_q[$];     // live stream entries awaiting delivery to decode
    int          epoch    = 0;
    logic [31:0] exp_pc   = BASE;
    int          last_due = 0;
    int          cyc      = 0;
    bit          started  = 1'b0;
    bit          popped   = 1'b0;
    int          lat_min  = 1;
    int          lat_rand = 0;
    logic [31:0] data_xor = 32'h0;

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;
    int          del_cnt = 0;
    bit          first_seen = 1'b0;
    logic [31:0] first_pc = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: present the oldest outstanding response once its latency expires
    initial begin
        resp_valid_i = 1'b0;
        resp_data_i  = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
                resp_valid_i = 1'b1;
                resp_data_i  = mem_q[0].data;
            end else begin
                resp_valid_i = 1'b0;
                resp_data_i  = $urandom;
            end
        end
    end

    // Output monitor: compare decode-side outputs with the head of the stream
    bit exp_v;
    always @(negedge clk) begin
        #2;
        popped = 1'b0;
        if (started) begin
            exp_v = (exp_q.size() > 0) && exp_q[0].filled;
            check("valid_o", valid_o, exp_v);
            if (exp_v) begin
                check("pc_o", pc_o, exp_q[0].pc);
                check("insn_o", insn_o, exp_q[0].insn);
            end else begin
                check("pc_o_idle", pc_o, 0);
                check("insn_o_idle", insn_o, 0);
            end
            if (valid_o && exp_v && ready_i && rst && !redirect_i) begin
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_pc   = pc_o;
                end
                void'(exp_q.pop_front());
                popped = 1'b1;
                del_cnt++;
            end
        end
    end

    // Request/response monitor: check issue side and advance the model
    int   stale;
    int   occ;
    bit   exp_rv;
    bit   found;
    mem_t m;
    exp_t e;
    int   due;
    always @(negedge clk) begin
        #3;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        occ    = exp_q.size() + stale + (popped ? 1 : 0);
        exp_rv = rst && !redirect_i && (occ < DEPTH);
        if (started) begin
            check("req_valid_o", req_valid_o, exp_rv);
            if (req_valid_o && exp_rv) check("req_addr_o", req_addr_o, exp_pc);
        end
        if (!rst) begin
            mem_q.delete();
            exp_q.delete();
            exp_pc   = BASE;
            last_due = 0;
            started  = 1'b1;
        end else begin
            if (resp_valid_i && mem_q.size() > 0) begin
                m = mem_q.pop_front();
                if (m.epoch == epoch && !redirect_i) begin
                    found = 1'b0;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (!found && !exp_q[k].filled) begin
                            exp_q[k].filled = 1'b1;
                            found = 1'b1;
                        end
                    end
                end
            end
            if (redirect_i) begin
                exp_q.delete();
                epoch++;
                exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
            end else if (req_valid_o && req_ready_i) begin
                due = cyc + 1 + lat_min + $urandom_range(0, lat_rand);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.addr  = exp_pc;
                m.data  = exp_pc ^ data_xor;
                m.epoch = epoch;
                m.due   = due;
                mem_q.push_back(m);
                e.pc     = exp_pc;
                e.insn   = exp_pc ^ data_xor;
                e.filled = 1'b0;
                exp_q.push_back(e);
                exp_pc = exp_pc + 32'd4;
                acc_cnt++;
            end
        end
    end

    // Hold reset for n cycles; returns inside the first released cycle
    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        rst     = 1'b1;
        acc_cnt = 0;
        del_cnt = 0;
    endtask

    // Stimulus
    initial begin
        rst           = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        req_ready_i   = 1'b1;
        ready_i       = 1'b1;

        // Streaming with single-cycle memory, response data equals address
        lat_min = 1; lat_rand = 0; data_xor = 32'h0;
        do_reset(2);
        repeat (11) @(negedge clk);
        check("t1_deliveries", del_cnt >= 5, 1);

        // Decode stalled: queue fills to two, head holds steady, then drains
        ready_i = 1'b0;
        do_reset(2);
        repeat (13) @(negedge clk);
        check("t2_accepts_when_stalled", acc_cnt, 2);
        check("t2_nothing_delivered", del_cnt, 0);
        ready_i = 1'b1;
        repeat (8) @(negedge clk);

        // Slow memory, redirect with two requests in flight
        lat_min = 3; data_xor = 32'h5A5A_5A5A;
        do_reset(2);
        @(negedge clk);
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h0100_0103; first_seen = 1'b0;
        @(negedge clk);
        redirect_i = 1'b0;
        repeat (15) @(negedge clk);
        check("t3_seen", first_seen, 1);
        check("t3_first_pc", first_pc, 32'h0100_0100);

        // Redirect while a response arrives, one FILLED + one RESERVED
        lat_min = 1; ready_i = 1'b0;
        do_reset(2);
        @(negedge clk);
        @(negedge clk);
        redirect_i = 1'b1; redirect_pc_i = 32'h0100_0200; ready_i = 1'b1; first_seen = 1'b0;
        @(negedge clk);
        redirect_i = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_seen", first_seen, 1);
        check("t4_first_pc", first_pc, 32'h0100_0200);

        // Redirect near the top of the address space to exercise wrap
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8; first_seen = 1'b0;
        @(negedge clk);
        redirect_i = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_first_pc", first_pc, 32'hFFFF_FFF8);

        // Reset pulse with two requests in flight
        lat_min = 3;
        do_reset(2);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; first_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_first_pc", first_pc, BASE);

        // Random traffic
        lat_min = 1; lat_rand = 3; data_xor = $urandom;
        del_cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            rst         = ($urandom_range(0, 299) != 0);
            req_ready_i = ($urandom_range(0, 9) < 7);
            ready_i     = ($urandom_range(0, 9) < 6);
            redirect_i  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                redirect_pc_i = $urandom;
        end
        @(negedge clk);
        rst = 1'b1; redirect_i = 1'b0;
        check("rand_deliveries", del_cnt > 100, 1);
        @(negedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of decode.
- Generates sequential PCs and issues read requests to instruction memory over a valid/ready request channel. It accepts in-order responses and buffers {pc, insn} pairs in a 2-entry queue.
- Presents those pairs to decode on insn_o/pc_o with a valid/ready handshake.
- Handles redirects from execute (branch/jump) by flushing buffered entries and discarding responses still in flight.

Parameters:
- AWIDTH, 32, address/PC width.
- DWIDTH, 32, instruction width.
- BASEADDR, 32'h0100_0000, PC loaded on reset.
- DEPTH, 2, queue entries; also the maximum number of outstanding requests. Legal values: 2 or 4.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- req_valid_o  out  1  memory read request valid.
- req_addr_o  out  AWIDTH  request address, always word-aligned.
- req_ready_i  in  1  memory accepts the request this cycle.
- resp_valid_i  in  1  response data valid; responses return in request order.
- resp_data_i  in  DWIDTH  instruction word.
- redirect_i  in  1  execute redirect strobe.
- redirect_pc_i  in  AWIDTH  redirect target.
- valid_o  out  1  head entry available to decode.
- ready_i  in  1  decode consumes the head this cycle.
- insn_o  out  DWIDTH  head instruction.
- pc_o  out  AWIDTH  head PC.

Behaviour:
- Reset (rst==0 at posedge):
  - fetch PC <= BASEADDR.
  - All entries invalid; drop_cnt <= 0.
  - Next cycle: req_valid_o=0 while rst==0, valid_o=0, insn_o=0, pc_o=0.
- Entry state: each entry is FREE, RESERVED (request accepted, data pending) or FILLED. Entries are allocated and retired in FIFO order using head/tail pointers that wrap modulo DEPTH.
- Issue:
  - req_valid_o = rst & ~redirect_i & (reserved + filled + drop_cnt < DEPTH).
  - req_addr_o = fetch PC.
  - A same-cycle dequeue does not free a slot for issue; there is no combinational ready_i->req_valid_o path.
  - On req_valid_o & req_ready_i: tail entry <= RESERVED with pc=fetch PC; fetch PC += 4 (wraps 0xFFFF_FFFC -> 0x0000_0000); tail advances.
- Response:
  - If drop_cnt>0: data discarded, drop_cnt decrements.
  - Else: oldest RESERVED entry <= FILLED with insn=resp_data_i.
  - resp_valid_i with nothing pending is a protocol error and is ignored (no state change).
- Output:
  - valid_o=1 iff the head entry is FILLED (registered). A response therefore appears on valid_o the cycle after resp_valid_i.
  - Minimum request-accept to valid_o latency is L+1 cycles, where L is the memory response latency (L>=1).
  - insn_o/pc_o reflect the head entry and hold stable while valid_o & ~ready_i.
  - valid_o & ready_i retires the head.
  - When valid_o=0, insn_o and pc_o are 0.
- Redirect (redirect_i=1 at posedge; dominates all other events that cycle):
  - fetch PC <= {redirect_pc_i[AWIDTH-1:2], 2'b00}.
  - All entries -> FREE; pointers reset.
  - drop_cnt <= drop_cnt + (RESERVED count) - (resp_valid_i ? 1 : 0). A response arriving in the redirect cycle is discarded and counted against the pending drops.
  - A same-cycle dequeue is ignored. valid_o=0 in the following cycle.
  - req_valid_o=0 during the redirect cycle; fetch resumes the next cycle subject to capacity, with drop_cnt counting toward capacity.
- Simultaneous request accept, response and dequeue (no redirect) are all applied in the same cycle.
- Reset mid-operation discards all state, including drop_cnt. The memory model must also be reset.

Test Plan:
- Reset release, memory L=1, req_ready_i=1, ready_i=1, resp_data = address -> req_addr_o sequence 0x01000000, 0x01000004, 0x01000008; first valid_o with pc_o=0x01000000 exactly 2 cycles after the first accept; then one instruction per cycle; insn_o==pc_o.
- ready_i=0 throughout -> exactly 2 requests accepted, then req_valid_o=0; valid_o=1 with pc_o=0x01000000 stable for 10 cycles. Raising ready_i then drains 0x01000000, 0x01000004 and fetching resumes at 0x01000008.
- Memory L=3 with 2 requests outstanding; redirect_i with redirect_pc_i=0x01000103 -> both late responses dropped; next valid_o shows pc_o=0x01000100 with the data fetched from 0x01000100.
- Redirect in the same cycle as resp_valid_i, queue holding 1 FILLED + 1 RESERVED -> no valid_o for the old stream; drop_cnt=0 afterwards; first post-redirect entry carries the redirect PC.
- Redirect to 0xFFFFFFF8 -> requests issued to 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; pc_o follows the same order.
- rst=0 for one cycle mid-stream with 2 RESERVED entries (memory also reset) -> next cycle valid_o=0, insn_o=0, pc_o=0, req_valid_o=0; after release the first request address is 0x01000000.
